// File: rtl/stream_feeder.sv
// stream_feeder: per-channel script replayer driving CNN buffer write ports via wen/ready.
// Optional feature: define STREAM_FEEDER_TAIL_EN to append flag-marked flush words per channel.
module stream_feeder #(
  parameter int unsigned DATA_WIDTH   = 18,
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned SCRIPT_DEPTH = 32,
  parameter int unsigned ADDR_WIDTH   = $clog2(SCRIPT_DEPTH),
  parameter int unsigned GAP_WIDTH    = 8,
  parameter int unsigned TAIL_WIDTH   = 5,
  parameter int unsigned CH_WIDTH     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         load_en,
  input  logic [CH_WIDTH-1:0]                          load_ch,
  input  logic [ADDR_WIDTH-1:0]                        load_addr,
  input  logic                                         load_kind,
  input  logic [DATA_WIDTH-1:0]                        load_data,
  input  logic [CHANNELS*(ADDR_WIDTH+1)-1:0]           length,
  input  logic [GAP_WIDTH-1:0]                         gap,
  input  logic [TAIL_WIDTH-1:0]                        tail_len,
  input  logic                                         start,
  output logic [CHANNELS*DATA_WIDTH-1:0]               out_data,
  output logic [CHANNELS-1:0]                          out_wen,
  input  logic [CHANNELS-1:0]                          out_ready,
  output logic                                         busy,
  output logic                                         done,
  output logic [CHANNELS*(ADDR_WIDTH+TAIL_WIDTH+1)-1:0] xfer_count
);

  localparam int unsigned LenW  = ADDR_WIDTH + 1;
  localparam int unsigned XferW = ADDR_WIDTH + TAIL_WIDTH + 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDrive, StGap, StSkip, StTail, StFin
  } state_e;

  // {kind, data}; deliberately not reset so scripts survive a reset
  logic [DATA_WIDTH:0] script_q [CHANNELS][SCRIPT_DEPTH];

  logic [CHANNELS-1:0] running;
  logic [CHANNELS-1:0] fin_vec;
  logic                all_fin;
  logic                done_q;

  assign busy    = |running;
  assign all_fin = &fin_vec;
  assign done    = done_q;

  always_ff @(posedge clk) begin
    if (load_en && !busy && (32'(load_ch) < CHANNELS)) begin
      script_q[load_ch][load_addr] <= {load_kind, load_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= 1'b0;
    else        done_q <= all_fin;
  end

`ifndef STREAM_FEEDER_TAIL_EN
  logic unused_tail_len;
  assign unused_tail_len = ^tail_len;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_e                state_q, state_d, adv_state;
    logic [LenW-1:0]       ptr_q, ptr_d, len_q, len_d, next_ptr, len_in;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d, cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [XferW-1:0]      xfer_q, xfer_d;
    logic [DATA_WIDTH:0]   entry;
`ifdef STREAM_FEEDER_TAIL_EN
    logic                  in_tail_q, in_tail_d;
    logic [TAIL_WIDTH-1:0] idx_q, idx_d, tlen_q, tlen_d;
`endif

    assign len_in = length[c*LenW +: LenW];
    assign entry  = script_q[c][ptr_q[ADDR_WIDTH-1:0]];

    // Where to go once the current entry (or tail word) is finished
    always_comb begin
      next_ptr = (state_q == StFetch) ? ptr_q + LenW'(1) : ptr_q;
`ifdef STREAM_FEEDER_TAIL_EN
      if (in_tail_q)              adv_state = (idx_q < tlen_q) ? StTail : StFin;
      else if (next_ptr < len_q)  adv_state = StFetch;
      else                        adv_state = (tlen_q != '0) ? StTail : StFin;
`else
      adv_state = (next_ptr < len_q) ? StFetch : StFin;
`endif
    end

    always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      gap_d   = gap_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      xfer_d  = xfer_q;
`ifdef STREAM_FEEDER_TAIL_EN
      in_tail_d = in_tail_q;
      idx_d     = idx_q;
      tlen_d    = tlen_q;
`endif
      case (state_q)
        StIdle: begin
          if (start && !busy) begin
            len_d  = len_in;
            gap_d  = gap;
            ptr_d  = '0;
            xfer_d = '0;
`ifdef STREAM_FEEDER_TAIL_EN
            tlen_d    = tail_len;
            idx_d     = '0;
            in_tail_d = 1'b0;
`endif
            if (len_in != '0) state_d = StFetch;
`ifdef STREAM_FEEDER_TAIL_EN
            else if (tail_len != '0) state_d = StTail;
`endif
            else state_d = StFin;
          end
        end
        StFetch: begin
          word_d = entry[DATA_WIDTH-1:0];
          ptr_d  = next_ptr;
          if (entry[DATA_WIDTH]) begin
            state_d = StDrive;
          end else if (entry[GAP_WIDTH-1:0] != '0) begin
            cnt_d   = entry[GAP_WIDTH-1:0] - GAP_WIDTH'(1);
            state_d = StSkip;
          end else begin
            state_d = adv_state;
          end
        end
        StDrive: begin
          if (out_ready[c]) begin
            xfer_d = xfer_q + XferW'(1);
            if (gap_q != '0) begin
              cnt_d   = gap_q - GAP_WIDTH'(1);
              state_d = StGap;
            end else begin
              state_d = adv_state;
            end
          end
        end
        StGap, StSkip: begin
          if (cnt_q == '0) state_d = adv_state;
          else             cnt_d   = cnt_q - GAP_WIDTH'(1);
        end
        StTail: begin
`ifdef STREAM_FEEDER_TAIL_EN
          word_d                 = '0;
          word_d[DATA_WIDTH-1]   = (idx_q == '0);
          word_d[DATA_WIDTH-2]   = (idx_q == tlen_q - TAIL_WIDTH'(1));
          idx_d                  = idx_q + TAIL_WIDTH'(1);
          state_d                = StDrive;
`else
          state_d = StFin;
`endif
        end
        StFin: begin
          if (all_fin) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
`ifdef STREAM_FEEDER_TAIL_EN
      if (state_d == StTail) in_tail_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= StIdle;
        ptr_q   <= '0;
        len_q   <= '0;
        gap_q   <= '0;
        cnt_q   <= '0;
        word_q  <= '0;
        xfer_q  <= '0;
`ifdef STREAM_FEEDER_TAIL_EN
        in_tail_q <= 1'b0;
        idx_q     <= '0;
        tlen_q    <= '0;
`endif
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        len_q   <= len_d;
        gap_q   <= gap_d;
        cnt_q   <= cnt_d;
        word_q  <= word_d;
        xfer_q  <= xfer_d;
`ifdef STREAM_FEEDER_TAIL_EN
        in_tail_q <= in_tail_d;
        idx_q     <= idx_d;
        tlen_q    <= tlen_d;
`endif
      end
    end

    assign out_wen[c]                        = (state_q == StDrive);
    assign out_data[c*DATA_WIDTH +: DATA_WIDTH] = (state_q == StDrive) ? word_q : '0;
    assign xfer_count[c*XferW +: XferW]      = xfer_q;
    assign running[c]                        = (state_q != StIdle);
    assign fin_vec[c]                        = (state_q == StFin);
  end

endmodule

// File: tb/tb_stream_feeder.sv
// tb_stream_feeder: directed, table-driven bench for stream_feeder (3 channels, 18-bit words).
module tb_stream_feeder;
  localparam int DW = 18;
  localparam int AW = 5;
  localparam int GW = 8;
  localparam int TW = 5;
  localparam int CW = 2;
  localparam int LW = 6;
  localparam int XW = 11;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_en = 1'b0;
  logic [CW-1:0]     load_ch = '0;
  logic [AW-1:0]     load_addr = '0;
  logic              load_kind = 1'b0;
  logic [DW-1:0]     load_data = '0;
  logic [3*LW-1:0]   length = '0;
  logic [GW-1:0]     gap = '0;
  logic [TW-1:0]     tail_len = '0;
  logic              start = 1'b0;
  logic [3*DW-1:0]   out_data;
  logic [2:0]        out_wen;
  logic [2:0]        out_ready = 3'b111;
  logic              busy;
  logic              done;
  logic [3*XW-1:0]   xfer_count;

  stream_feeder #(
    .DATA_WIDTH(DW), .CHANNELS(3), .SCRIPT_DEPTH(32), .ADDR_WIDTH(AW),
    .GAP_WIDTH(GW), .TAIL_WIDTH(TW), .CH_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_ch(load_ch),
    .load_addr(load_addr), .load_kind(load_kind), .load_data(load_data),
    .length(length), .gap(gap), .tail_len(tail_len), .start(start),
    .out_data(out_data), .out_wen(out_wen), .out_ready(out_ready),
    .busy(busy), .done(done), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wen;
    logic [DW-1:0] data;
    logic          busy;
    logic          done;
    logic [XW-1:0] xfer;
  } step_t;

  step_t tbl [11];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_entry(input int ch, input int addr, input logic kind,
                            input logic [DW-1:0] data);
    @(negedge clk);
    load_en = 1'b1; load_ch = CW'(ch); load_addr = AW'(addr);
    load_kind = kind; load_data = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Returns at the negedge just after the start edge T
  task automatic pulse_start(input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                             input logic [LW-1:0] l2, input logic [GW-1:0] g,
                             input logic [TW-1:0] tl);
    @(negedge clk);
    length = {l2, l1, l0}; gap = g; tail_len = tl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, done, 1'b1);
    @(negedge clk);
  endtask

  task automatic run_table(input string tag, input bit disturb);
    pulse_start(6'd4, 6'd0, 6'd0, 8'd0, 5'd0);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("%s k%0d wen0", tag, k), out_wen[0], tbl[k].wen);
      check($sformatf("%s k%0d data0", tag, k), out_data[DW-1:0], tbl[k].data);
      check($sformatf("%s k%0d busy", tag, k), busy, tbl[k].busy);
      check($sformatf("%s k%0d done", tag, k), done, tbl[k].done);
      check($sformatf("%s k%0d xfer0", tag, k), xfer_count[XW-1:0], tbl[k].xfer);
      if (disturb && k == 2) begin
        load_en = 1'b1; load_ch = '0; load_addr = 5'd1; load_kind = 1'b1;
        load_data = 18'h3ffff; start = 1'b1; length = {6'd1, 6'd1, 6'd1}; gap = 8'd5;
      end
      if (k == 3) begin
        load_en = 1'b0; start = 1'b0; gap = 8'd0;
      end
    end
  endtask

  initial begin
    int n;
    tbl[0]  = '{1'b0, 18'h0, 1'b1, 1'b0, 11'd0};
    tbl[1]  = '{1'b1, 18'h1, 1'b1, 1'b0, 11'd0};
    tbl[2]  = '{1'b0, 18'h0, 1'b1, 1'b0, 11'd1};
    tbl[3]  = '{1'b1, 18'h2, 1'b1, 1'b0, 11'd1};
    tbl[4]  = '{1'b0, 18'h0, 1'b1, 1'b0, 11'd2};
    tbl[5]  = '{1'b1, 18'h3, 1'b1, 1'b0, 11'd2};
    tbl[6]  = '{1'b0, 18'h0, 1'b1, 1'b0, 11'd3};
    tbl[7]  = '{1'b1, 18'h4, 1'b1, 1'b0, 11'd3};
    tbl[8]  = '{1'b0, 18'h0, 1'b1, 1'b0, 11'd4};
    tbl[9]  = '{1'b0, 18'h0, 1'b0, 1'b1, 11'd4};
    tbl[10] = '{1'b0, 18'h0, 1'b0, 1'b0, 11'd4};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst wen", out_wen, 3'b000);
    check("rst data", out_data, '0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst xfer", xfer_count, '0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) load_entry(0, i, 1'b1, DW'(i + 1));
    load_entry(1, 0, 1'b1, 18'h155);
    load_entry(2, 0, 1'b1, 18'h0abc);
    load_entry(2, 1, 1'b0, 18'd50);
    load_entry(2, 2, 1'b1, 18'h123);

    // Basic four-word script, ready high, gap 0
    run_table("basic", 1'b0);

    // Ready stall on channel 1
    out_ready = 3'b101;
    pulse_start(6'd0, 6'd1, 6'd0, 8'd0, 5'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("stall k%0d wen1", k), out_wen[1], 1'b1);
      check($sformatf("stall k%0d data1", k), out_data[2*DW-1:DW], 18'h155);
    end
    out_ready = 3'b111;
    @(negedge clk);
    check("stall accept wen1", out_wen[1], 1'b0);
    check("stall xfer1", xfer_count[2*XW-1:XW], 11'd1);
    @(negedge clk);
    check("stall done", done, 1'b1);

    // WRITE, SKIP(50), WRITE with gap 1 on channel 2
    pulse_start(6'd0, 6'd0, 6'd3, 8'd1, 5'd0);
    @(negedge clk);
    check("skip w0 wen2", out_wen[2], 1'b1);
    check("skip w0 data2", out_data[3*DW-1:2*DW], 18'h0abc);
    @(negedge clk);
    n = 0;
    while (!out_wen[2] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("skip latency", n, 53);
    check("skip w1 data2", out_data[3*DW-1:2*DW], 18'h123);
    wait_done("skip done");
    check("skip xfer2", xfer_count[3*XW-1:2*XW], 11'd2);

    // Reset in the middle of a run, then replay from entry 0
    pulse_start(6'd4, 6'd0, 6'd0, 8'd0, 5'd0);
    for (int k = 0; k < 3; k++) @(negedge clk);
    check("mid xfer0", xfer_count[XW-1:0], 11'd1);
    reset = 1'b0;
    #1;
    check("mid rst wen", out_wen, 3'b000);
    check("mid rst data", out_data, '0);
    check("mid rst busy", busy, 1'b0);
    check("mid rst done", done, 1'b0);
    check("mid rst xfer", xfer_count, '0);
    @(negedge clk);
    reset = 1'b1;
    run_table("replay", 1'b0);

    // start and load_en while busy are ignored
    run_table("busy", 1'b1);
    run_table("after", 1'b0);

`ifdef STREAM_FEEDER_TAIL_EN
    begin
      logic [DW-1:0] tail_exp [4];
      tail_exp[0] = 18'h20000; tail_exp[1] = 18'h0;
      tail_exp[2] = 18'h0;     tail_exp[3] = 18'h10000;
      pulse_start(6'd4, 6'd0, 6'd0, 8'd0, 5'd4);
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        if (k >= 9 && (k % 2) == 1) begin
          check($sformatf("tail k%0d wen0", k), out_wen[0], 1'b1);
          check($sformatf("tail k%0d data0", k), out_data[DW-1:0], tail_exp[(k - 9) / 2]);
        end
      end
      check("tail xfer0", xfer_count[XW-1:0], 11'd8);
      wait_done("tail done");
      tail_len = '0;
    end
`endif

    // load_en and start in the same idle cycle: first FETCH sees the new word
    @(negedge clk);
    load_en = 1'b1; load_ch = '0; load_addr = '0; load_kind = 1'b1; load_data = 18'h777;
    length = {6'd0, 6'd0, 6'd1}; gap = '0; start = 1'b1;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    @(negedge clk);
    check("same-cycle wen0", out_wen[0], 1'b1);
    check("same-cycle data0", out_data[DW-1:0], 18'h777);
    wait_done("same-cycle done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
